// File: rtl/kbd_event_rx.sv
// Scancode-set-2 event decoder with modifier tracking and an event FIFO.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   code_valid, code : byte strobe and scancode from ps2_rx
//   rd_en            : pop the FIFO head (ignored when empty)
//   ev_data          : head entry {brk, ext, caps, alt, ctrl, shift, code}
//   ev_empty         : FIFO empty
//   ev_count         : entries held
//   overflow         : sticky, an event was dropped on full
//   caps_on          : caps-lock state
//   toggle_caps      : one-cycle pulse asking for an LED update
module kbd_event_rx #(
   parameter int DEPTH         = 8,
   parameter int EMIT_BREAK    = 0,
   parameter int FILTER_REPEAT = 1,
   parameter int TIMEOUT       = 50000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     code_valid,
   input  logic [7:0]               code,
   input  logic                     rd_en,
   output logic [13:0]              ev_data,
   output logic                     ev_empty,
   output logic [$clog2(DEPTH):0]   ev_count,
   output logic                     overflow,
   output logic                     caps_on,
   output logic                     toggle_caps
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_EXT     = 3'd1;
   localparam logic [2:0] S_BRK     = 3'd2;
   localparam logic [2:0] S_EXT_BRK = 3'd3;
   localparam logic [2:0] S_PAUSE   = 3'd4;

   logic [2:0]    r_state;
   logic [2:0]    r_pcnt;
   logic [TW-1:0] r_to;
   logic          r_shl, r_shr, r_ctrl, r_alt;
   logic          r_caps, r_caps_held, r_toggle;
   logic          r_last_vld;
   logic [8:0]    r_last;
   logic [13:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [CW-1:0] r_cnt;
   logic          r_ovf;

   logic [2:0]    w_nstate;
   logic [2:0]    w_pcnt;
   logic          w_key, w_brk, w_ext, w_pause, w_timeout;
   logic          w_shift_code, w_is_ctrl, w_is_alt, w_is_caps;
   logic          w_match, w_push, w_rd, w_wr, w_full;
   logic [3:0]    w_mods;
   logic [13:0]   w_ev;

   assign w_timeout = !code_valid && (r_state != S_IDLE)
                    && (r_to == TW'(TIMEOUT - 1));

   always_comb begin
      w_nstate = r_state;
      w_pcnt   = r_pcnt;
      w_key    = 1'b0;
      w_brk    = 1'b0;
      w_ext    = 1'b0;
      w_pause  = 1'b0;
      if (w_timeout) begin
         w_nstate = S_IDLE;
      end else if (code_valid) begin
         case (r_state)
            S_IDLE: begin
               if (code == 8'hE0) w_nstate = S_EXT;
               else if (code == 8'hF0) w_nstate = S_BRK;
               else if (code == 8'hE1) begin
                  w_nstate = S_PAUSE;
                  w_pcnt   = 3'd7;
               end else w_key = 1'b1;
            end
            S_EXT: begin
               if (code == 8'hF0) w_nstate = S_EXT_BRK;
               else if (code == 8'hE0 || code == 8'hE1) w_nstate = S_EXT;
               else if (code == 8'h12 || code == 8'h59) w_nstate = S_IDLE;
               else begin
                  w_key    = 1'b1;
                  w_ext    = 1'b1;
                  w_nstate = S_IDLE;
               end
            end
            S_BRK: begin
               w_key    = 1'b1;
               w_brk    = 1'b1;
               w_nstate = S_IDLE;
            end
            S_EXT_BRK: begin
               w_key    = 1'b1;
               w_brk    = 1'b1;
               w_ext    = 1'b1;
               w_nstate = S_IDLE;
            end
            S_PAUSE: begin
               if (r_pcnt == 3'd1) begin
                  w_pause  = 1'b1;
                  w_nstate = S_IDLE;
               end else w_pcnt = r_pcnt - 3'd1;
            end
            default: w_nstate = S_IDLE;
         endcase
      end
   end

   assign w_shift_code = (code == 8'h12) || (code == 8'h59);
   assign w_is_ctrl    = (code == 8'h14);
   assign w_is_alt     = (code == 8'h11);
   assign w_is_caps    = !w_ext && (code == 8'h58);
   assign w_match      = r_last_vld && (r_last == {w_ext, code});
   assign w_mods       = {r_caps, r_alt, r_ctrl, r_shl | r_shr};

   // Modifiers and caps are state only; everything else may be queued.
   always_comb begin
      w_push = w_pause;
      if (w_key && !w_shift_code && !w_is_ctrl && !w_is_alt && !w_is_caps) begin
         if (w_brk) w_push = (EMIT_BREAK != 0);
         else       w_push = !((FILTER_REPEAT != 0) && w_match);
      end
   end

   assign w_ev = w_pause ? {2'b01, w_mods, 8'hE1}
                         : {w_brk, w_ext, w_mods, code};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_pcnt      <= 3'd0;
         r_to        <= '0;
         r_shl       <= 1'b0;
         r_shr       <= 1'b0;
         r_ctrl      <= 1'b0;
         r_alt       <= 1'b0;
         r_caps      <= 1'b0;
         r_caps_held <= 1'b0;
         r_toggle    <= 1'b0;
         r_last_vld  <= 1'b0;
         r_last      <= '0;
      end else begin
         r_state  <= w_nstate;
         r_pcnt   <= w_pcnt;
         r_toggle <= 1'b0;
         if (code_valid || r_state == S_IDLE || w_timeout) r_to <= '0;
         else r_to <= r_to + 1'b1;
         if (w_key) begin
            // E0 F0 12/59 is a fake shift release; it must not drop shift.
            if (w_shift_code) begin
               if (!w_ext) begin
                  if (code == 8'h12) r_shl <= !w_brk;
                  else               r_shr <= !w_brk;
               end
            end else if (w_is_ctrl) begin
               r_ctrl <= !w_brk;
            end else if (w_is_alt) begin
               r_alt <= !w_brk;
            end else if (w_is_caps) begin
               if (!w_brk && !r_caps_held) begin
                  r_caps   <= !r_caps;
                  r_toggle <= 1'b1;
               end
               r_caps_held <= !w_brk;
            end else if (!w_brk) begin
               r_last     <= {w_ext, code};
               r_last_vld <= 1'b1;
            end else if (w_match) begin
               r_last_vld <= 1'b0;
            end
         end
      end
   end

   assign w_full = (r_cnt == CW'(DEPTH));
   assign w_rd   = rd_en && (r_cnt != '0);
   assign w_wr   = w_push && (!w_full || w_rd);

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wp] <= w_ev;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_wr) r_wp <= r_wp + 1'b1;
         if (w_rd) r_rp <= r_rp + 1'b1;
         if (w_wr && !w_rd)      r_cnt <= r_cnt + 1'b1;
         else if (w_rd && !w_wr) r_cnt <= r_cnt - 1'b1;
         if (w_push && !w_wr) r_ovf <= 1'b1;
      end
   end

   assign ev_data     = (r_cnt == '0) ? 14'd0 : r_mem[r_rp];
   assign ev_empty    = (r_cnt == '0);
   assign ev_count    = r_cnt;
   assign overflow    = r_ovf;
   assign caps_on     = r_caps;
   assign toggle_caps = r_toggle;

endmodule

// File: tb/tb_kbd_event_rx.sv
// Directed bench: two decoders (break events off / on) share one stimulus.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_kbd_event_rx;

   localparam int TO = 16;

   logic       clk, rst, code_valid, rd_en;
   logic [7:0] code;

   logic [13:0] d0_data, d1_data;
   logic        d0_empty, d1_empty;
   logic [3:0]  d0_cnt, d1_cnt;
   logic        d0_ovf, d1_ovf, d0_caps, d1_caps, d0_tog, d1_tog;

   int n_cmp = 0;
   int n_bad = 0;

   kbd_event_rx #(.DEPTH(8), .EMIT_BREAK(0), .FILTER_REPEAT(1),
                  .TIMEOUT(TO)) u_d0 (
      .clk(clk), .rst(rst), .code_valid(code_valid), .code(code),
      .rd_en(rd_en), .ev_data(d0_data), .ev_empty(d0_empty),
      .ev_count(d0_cnt), .overflow(d0_ovf), .caps_on(d0_caps),
      .toggle_caps(d0_tog));

   kbd_event_rx #(.DEPTH(8), .EMIT_BREAK(1), .FILTER_REPEAT(1),
                  .TIMEOUT(TO)) u_d1 (
      .clk(clk), .rst(rst), .code_valid(code_valid), .code(code),
      .rd_en(rd_en), .ev_data(d1_data), .ev_empty(d1_empty),
      .ev_count(d1_cnt), .overflow(d1_ovf), .caps_on(d1_caps),
      .toggle_caps(d1_tog));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      code_valid = 1'b1;
      code       = b;
      @(negedge clk);
      code_valid = 1'b0;
   endtask

   task automatic pop();
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] fill [8];
      fill = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43};
      code_valid = 1'b0;
      code       = 8'h00;
      rd_en      = 1'b0;
      rst        = 1'b1;
      @(negedge clk);
      do_reset();

      chk("rst_empty", 16'(d0_empty), 16'h1);
      chk("rst_count", 16'(d0_cnt), 16'h0);
      chk("rst_data", 16'(d0_data), 16'h0);
      chk("rst_ovf", 16'(d0_ovf), 16'h0);
      chk("rst_caps", 16'(d0_caps), 16'h0);
      chk("rst_tog", 16'(d0_tog), 16'h0);

      // make then break of 1C
      send(8'h1C);
      chk("mk_d0_data", 16'(d0_data), 16'h001C);
      chk("mk_d0_cnt", 16'(d0_cnt), 16'h1);
      send(8'hF0); send(8'h1C);
      chk("brk_d0_cnt", 16'(d0_cnt), 16'h1);
      chk("brk_d1_cnt", 16'(d1_cnt), 16'h2);
      pop();
      chk("pop_d0_empty", 16'(d0_empty), 16'h1);
      chk("pop_d1_head", 16'(d1_data), 16'h201C);

      // shifted key
      do_reset();
      send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
      send(8'hF0); send(8'h12);
      chk("sh_d1_head", 16'(d1_data), 16'h011C);
      chk("sh_d1_cnt", 16'(d1_cnt), 16'h2);
      chk("sh_d0_cnt", 16'(d0_cnt), 16'h1);
      send(8'h1C);
      pop();
      chk("sh_d1_brk", 16'(d1_data), 16'h211C);
      chk("sh_d0_clr", 16'(d0_data), 16'h001C);
      pop();
      chk("sh_d1_clr", 16'(d1_data), 16'h001C);

      // extended keys, fake shift
      do_reset();
      send(8'hE0); send(8'h12);
      chk("fake_sh_empty", 16'(d1_empty), 16'h1);
      send(8'hE0); send(8'h75);
      chk("ext_mk", 16'(d1_data), 16'h1075);
      send(8'hE0); send(8'hF0); send(8'h75);
      chk("ext_d1_cnt", 16'(d1_cnt), 16'h2);
      chk("ext_d0_cnt", 16'(d0_cnt), 16'h1);
      pop();
      chk("ext_brk", 16'(d1_data), 16'h3075);

      // repeat filter and caps
      do_reset();
      repeat (5) send(8'h1C);
      send(8'hF0); send(8'h1C);
      chk("rep_d0_cnt", 16'(d0_cnt), 16'h1);
      chk("rep_d1_cnt", 16'(d1_cnt), 16'h2);
      chk("rep_d0_head", 16'(d0_data), 16'h001C);
      send(8'h58);
      chk("caps_tog1", 16'(d0_tog), 16'h1);
      send(8'h58);
      chk("caps_tog_rep", 16'(d0_tog), 16'h0);
      chk("caps_on", 16'(d0_caps), 16'h1);
      send(8'hF0); send(8'h58);
      chk("caps_brk_on", 16'(d0_caps), 16'h1);
      chk("caps_noq", 16'(d0_cnt), 16'h1);
      send(8'h1C);
      chk("caps_key_cnt", 16'(d0_cnt), 16'h2);
      pop();
      chk("caps_key", 16'(d0_data), 16'h081C);

      // pause sequence and prefix timeout
      do_reset();
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0);
      chk("pause_pend", 16'(d0_cnt), 16'h0);
      send(8'h77);
      chk("pause_cnt", 16'(d1_cnt), 16'h1);
      chk("pause_data", 16'(d1_data), 16'h10E1);
      pop();
      send(8'hF0);
      repeat (TO - 1) @(negedge clk);
      send(8'h1C);
      chk("to_short_d0", 16'(d0_cnt), 16'h0);
      chk("to_short_d1", 16'(d1_data), 16'h201C);
      pop();
      send(8'hF0);
      repeat (TO) @(negedge clk);
      send(8'h1C);
      chk("to_d0", 16'(d0_data), 16'h001C);
      chk("to_d1", 16'(d1_data), 16'h001C);

      // fill, full read+write, overflow
      do_reset();
      for (int i = 0; i < 8; i++) send(fill[i]);
      chk("full_cnt", 16'(d0_cnt), 16'h8);
      chk("full_ovf", 16'(d0_ovf), 16'h0);
      chk("full_head", 16'(d0_data), 16'h0015);
      rd_en = 1'b1;
      send(8'h44);
      rd_en = 1'b0;
      chk("rw_cnt", 16'(d0_cnt), 16'h8);
      chk("rw_ovf", 16'(d0_ovf), 16'h0);
      chk("rw_head", 16'(d0_data), 16'h001D);
      send(8'h4B);
      chk("ovf_cnt", 16'(d0_cnt), 16'h8);
      chk("ovf_set", 16'(d0_ovf), 16'h1);
      chk("ovf_head", 16'(d0_data), 16'h001D);
      for (int i = 0; i < 8; i++) pop();
      chk("drain_empty", 16'(d0_empty), 16'h1);
      chk("ovf_sticky", 16'(d0_ovf), 16'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
